// File: rtl/cpu6_pkg.sv
// Shared definitions for the 6-bit CPU slice: datapath width, branch condition
// codes, flag bit positions and the branch-unit FSM encoding.
package cpu6_pkg;

    localparam int WIDTH = 6;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_C      = 3'd3;
    localparam logic [2:0] COND_NC     = 3'd4;
    localparam logic [2:0] COND_S      = 3'd5;
    localparam logic [2:0] COND_NS     = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    localparam int F_CF = 2;
    localparam int F_SF = 1;
    localparam int F_ZF = 0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/cond_eval_6_bit.sv
// Combinational branch-condition evaluator: decides whether br_cond is
// satisfied by a {cf, sf, zf} flag vector.
module cond_eval_6_bit (
    input  logic [2:0] flags,
    input  logic [2:0] br_cond,
    output logic       take
);
    import cpu6_pkg::*;

    always_comb begin
        // NOTE: default assigned before the case so no path leaves take unassigned (no latch).
        take = 1'b0;
        case (br_cond)
            COND_ALWAYS: take = 1'b1;
            COND_Z:      take =  flags[F_ZF];
            COND_NZ:     take = ~flags[F_ZF];
            COND_C:      take =  flags[F_CF];
            COND_NC:     take = ~flags[F_CF];
            COND_S:      take =  flags[F_SF];
            COND_NS:     take = ~flags[F_SF];
            COND_NEVER:  take = 1'b0;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit_6_bit.sv
// Flag register, branch resolution and program counter. Taken branches cost
// one REDIRECT bubble; an unconditional jump to its own address halts the unit.
module flag_branch_unit_6_bit #(
    parameter int               WIDTH    = cpu6_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic             cf_in,
    input  logic             sf_in,
    input  logic             zf_in,
    input  logic             pc_en,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] br_target,
    output logic             br_ready,
    output logic [WIDTH-1:0] pc,
    output logic [2:0]       flags,
    output logic             br_taken,
    output logic             halted
);
    import cpu6_pkg::*;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_next_pc;
    logic [2:0]       r_flags;
    logic [WIDTH-1:0] r_target;
    logic             r_self_loop;
    logic             r_br_taken;
    logic [2:0]       w_eff_flags;
    logic             w_take;
    logic             w_accept;
    logic             w_load_target;

    // A branch issued alongside its flag-setting ALU op must see the new flags.
    assign w_eff_flags = flag_we ? {cf_in, sf_in, zf_in} : r_flags;
    assign w_accept    = br_valid & br_ready;

    cond_eval_6_bit u_cond_eval (
        .flags   (w_eff_flags),
        .br_cond (br_cond),
        .take    (w_take)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_pc     = r_pc;
        w_load_target = 1'b0;
        case (r_state)
            RUN: begin
                if (w_accept && w_take) begin
                    w_next_state  = REDIRECT;
                    w_load_target = 1'b1;
                end else begin
                    w_next_pc = r_pc + WIDTH'(pc_en);
                end
            end
            REDIRECT: begin
                w_next_pc    = r_target;
                w_next_state = r_self_loop ? HALT : RUN;
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = RUN;
        endcase
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_pc        <= RESET_PC;
            r_flags     <= 3'b000;
            r_target    <= '0;
            r_self_loop <= 1'b0;
            r_br_taken  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_br_taken <= (r_state == REDIRECT);
            if (flag_we) begin
                r_flags <= {cf_in, sf_in, zf_in};
            end
            if (w_load_target) begin
                r_target    <= br_target;
                r_self_loop <= (br_cond == COND_ALWAYS) && (br_target == r_pc);
            end
        end
    end

    assign pc       = r_pc;
    assign flags    = r_flags;
    assign br_taken = r_br_taken;
    assign br_ready = (r_state == RUN);
    assign halted   = (r_state == HALT);

endmodule

// File: tb/tb_flag_branch_unit_6_bit.sv
// Self-checking bench for flag_branch_unit_6_bit: directed scenarios plus
// randomized traffic compared against a behavioural model each cycle.
module tb_flag_branch_unit_6_bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flag_we = 1'b0;
    logic       cf_in = 1'b0;
    logic       sf_in = 1'b0;
    logic       zf_in = 1'b0;
    logic       pc_en = 1'b0;
    logic       br_valid = 1'b0;
    logic [2:0] br_cond = 3'd0;
    logic [5:0] br_target = 6'd0;
    logic       br_ready;
    logic [5:0] pc;
    logic [2:0] flags;
    logic       br_taken;
    logic       halted;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    int  m_pc;
    int  m_flags;
    bit  m_pending;
    int  m_dest;
    bit  m_halt_after;
    bit  m_halted;
    bit  m_taken;

    flag_branch_unit_6_bit #(.WIDTH(6), .RESET_PC(6'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag_we   (flag_we),
        .cf_in     (cf_in),
        .sf_in     (sf_in),
        .zf_in     (zf_in),
        .pc_en     (pc_en),
        .br_valid  (br_valid),
        .br_cond   (br_cond),
        .br_target (br_target),
        .br_ready  (br_ready),
        .pc        (pc),
        .flags     (flags),
        .br_taken  (br_taken),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input int cond, input int f);
        bit c, s, z;
        c = f[2]; s = f[1]; z = f[0];
        case (cond)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return c;
            4: return !c;
            5: return s;
            6: return !s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_flags = 0; m_pending = 0; m_dest = 0;
        m_halt_after = 0; m_halted = 0; m_taken = 0;
    endfunction

    // One rising edge of the specified behaviour, using the inputs present at the edge.
    function automatic void model_step();
        int  eff;
        bit  ready;
        eff   = flag_we ? {cf_in, sf_in, zf_in} : m_flags;
        ready = !m_pending && !m_halted;
        m_taken = 0;
        if (m_halted) begin
            // frozen
        end else if (m_pending) begin
            m_pc      = m_dest;
            m_taken   = 1;
            m_pending = 0;
            m_halted  = m_halt_after;
        end else if (br_valid && ready && cond_holds(br_cond, eff)) begin
            m_pending    = 1;
            m_dest       = br_target;
            m_halt_after = (br_cond == 0) && (br_target == m_pc);
        end else begin
            m_pc = (m_pc + pc_en) % 64;
        end
        if (flag_we) m_flags = {cf_in, sf_in, zf_in};
    endfunction

    task automatic compare_all(input string where);
        check({where, ".pc"},       pc,       m_pc);
        check({where, ".flags"},    flags,    m_flags);
        check({where, ".br_ready"}, br_ready, !m_pending && !m_halted);
        check({where, ".br_taken"}, br_taken, m_taken);
        check({where, ".halted"},   halted,   m_halted);
    endtask

    task automatic tick(input string where);
        @(posedge clk);
        model_step();
        #1;
        compare_all(where);
    endtask

    task automatic idle_inputs();
        flag_we = 0; cf_in = 0; sf_in = 0; zf_in = 0;
        pc_en = 0; br_valid = 0; br_cond = 3'd7; br_target = 6'd0;
    endtask

    // Assert reset between edges and check it takes effect without a clock edge.
    task automatic async_reset(input string where);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check({where, ".rst_pc"},     pc,       0);
        check({where, ".rst_flags"},  flags,    0);
        check({where, ".rst_halted"}, halted,   0);
        check({where, ".rst_ready"},  br_ready, 1);
        check({where, ".rst_taken"},  br_taken, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_to(input int target_pc);
        idle_inputs();
        pc_en = 1;
        for (int i = 0; i < 64 && m_pc != target_pc; i++) tick("adv");
        check("adv.reached", pc, target_pc);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #3;
        async_reset("init");

        // Reset mid-run after ten counting cycles.
        pc_en = 1;
        for (int i = 0; i < 10; i++) tick("count");
        check("count.pc10", pc, 10);
        async_reset("midrun");

        // Wrap: 64 edges of pc_en return pc to 0.
        pc_en = 1;
        for (int i = 0; i < 64; i++) tick("wrap");
        check("wrap.zero", pc, 0);
        async_reset("wrap");

        // Bypass: branch on Z issued with the flag write that sets zf.
        run_to(5);
        flag_we = 1; zf_in = 1; br_valid = 1; br_cond = 3'd1; br_target = 6'd20; pc_en = 1;
        tick("byp.accept");
        check("byp.ready0", br_ready, 0);
        check("byp.pc5", pc, 5);
        idle_inputs();
        tick("byp.redir");
        check("byp.pc20", pc, 20);
        check("byp.taken", br_taken, 1);
        check("byp.flags", flags, 3'b001);
        tick("byp.after");
        check("byp.taken_pulse", br_taken, 0);
        async_reset("byp");

        // Not taken: zf=0, branch on Z with pc_en.
        run_to(7);
        br_valid = 1; br_cond = 3'd1; br_target = 6'd30; pc_en = 1;
        tick("nt");
        check("nt.pc8", pc, 8);
        check("nt.taken", br_taken, 0);
        check("nt.ready", br_ready, 1);
        idle_inputs();

        // Held request during REDIRECT.
        br_valid = 1; br_cond = 3'd0; br_target = 6'd25;
        tick("hold.first");
        br_target = 6'd40; pc_en = 1;
        tick("hold.redir");
        check("hold.pc25", pc, 25);
        tick("hold.accept");
        idle_inputs();
        tick("hold.redir2");
        check("hold.pc40", pc, 40);
        async_reset("hold");

        // Halt on self-loop.
        run_to(12);
        br_valid = 1; br_cond = 3'd0; br_target = 6'd12;
        tick("halt.accept");
        idle_inputs();
        tick("halt.redir");
        check("halt.pc", pc, 12);
        check("halt.halted", halted, 1);
        check("halt.ready", br_ready, 0);
        for (int i = 0; i < 5; i++) begin
            pc_en = 1; br_valid = 1; br_cond = 3'd0; br_target = 6'($urandom_range(0, 63));
            tick("halt.frozen");
        end
        flag_we = 1; cf_in = 1; sf_in = 1; zf_in = 0; br_valid = 0;
        tick("halt.flagwr");
        check("halt.flags", flags, 3'b110);
        check("halt.still", halted, 1);
        async_reset("halt");
        check("halt.cleared", halted, 0);

        // Randomized traffic with occasional reset and forced self-loops.
        for (int i = 0; i < 2000; i++) begin
            flag_we  = ($urandom_range(0, 3) == 0);
            cf_in    = 1'($urandom);
            sf_in    = 1'($urandom);
            zf_in    = 1'($urandom);
            pc_en    = 1'($urandom);
            br_valid = ($urandom_range(0, 2) == 0);
            br_cond  = 3'($urandom);
            br_target = 6'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                br_cond = 3'd0;
                br_target = 6'(m_pc);
            end
            tick("rand");
            if (i % 250 == 249) async_reset("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
